wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter LD_DEPTH, default 2, SHALL set the load-result buffer depth (power of two, 2..8).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 alu_valid  in  1  ALU result is presented this cycle.
REQ-005 alu_ready  out  1  ALU result is accepted this cycle.
REQ-006 alu_rd  in  5  ALU destination register.
REQ-007 alu_data  in  32  ALU result.
REQ-008 ld_valid  in  1  load result is presented this cycle.
REQ-009 ld_ready  out  1  load result is accepted this cycle.
REQ-010 ld_rd  in  5  load destination register.
REQ-011 ld_data  in  32  load result.
REQ-012 we  out  1  register-file write enable, registered.
REQ-013 rd_addr  out  5  register-file write address, registered.
REQ-014 rd_data_in  out  32  register-file write data, registered.
REQ-015 rs1_addr, rs2_addr  in  5 each  decode-stage read addresses, used for bypass.
REQ-016 rs1_fwd_hit, rs2_fwd_hit  out  1 each  the bypass value is valid.
REQ-017 rs1_fwd_data, rs2_fwd_data  out  32 each  bypass value.
REQ-018 busy_mask  out  32  bit n set while a buffered load targets register n.

Function
REQ-019 A transfer on either source SHALL occur when valid and ready are both high in the same cycle.
REQ-020 Load transfers SHALL push {ld_rd, ld_data} into a FIFO of LD_DEPTH entries, and ld_ready SHALL equal (count < LD_DEPTH).
REQ-021 Arbitration per cycle:
  - If the FIFO is full, the FIFO head SHALL pop and alu_ready SHALL be 0.
  - Otherwise alu_ready SHALL be 1, and an ALU transfer SHALL win.
  - If no ALU transfer occurs, a non-empty FIFO SHALL pop its head.
REQ-022 The winner SHALL appear on we, rd_addr and rd_data_in exactly one cycle after the transfer or pop.
REQ-023 The ALU-to-write-port latency SHALL be 1 cycle, and load latency SHALL be at least 2 cycles.
REQ-024 If no winner exists, we SHALL be 0 and rd_addr and rd_data_in SHALL hold their previous values.
REQ-025 A winner with rd = 0 SHALL be consumed but SHALL produce we = 0.
REQ-026 A simultaneous push and pop SHALL leave the count unchanged.
REQ-027 Pointers SHALL wrap modulo LD_DEPTH.
REQ-028 A push into a full FIFO SHALL be impossible because ld_ready = 0.
REQ-029 busy_mask SHALL be the OR-decode of the rd fields of all valid entries, excluding rd = 0, and SHALL be combinational from FIFO state.
REQ-030 Entries SHALL leave the FIFO in push order.

Reset
REQ-031 While rst = 0 the block SHALL hold these values, and a reset mid-operation SHALL discard all buffered loads:
  - FIFO count, read pointer and write pointer = 0
  - we = 0, rd_addr = 0, rd_data_in = 0
  - busy_mask = 0, both fwd_hit = 0, both fwd_data = 0
  - alu_ready = 1, ld_ready = 1
REQ-032 The first transfer SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-033 Macro WB_BYPASS_EN defined: each rsN_fwd_hit SHALL be (we && rd_addr != 0 && rd_addr == rsN_addr), and rsN_fwd_data SHALL be rd_data_in, both combinational.
REQ-034 Macro WB_BYPASS_EN undefined: the ports SHALL remain present, the fwd_hit outputs SHALL be tied to 0, the fwd_data outputs SHALL be tied to 0, and no comparators SHALL be synthesised.

Structure
REQ-035 A shared package SHALL hold:
  - XLEN = 32
  - REG_ADDR_W = 5
  - REG_ZERO = 5'd0
  - the write-request record {rd, data}
REQ-036 The FIFO SHALL be one sub-module, wb_ld_fifo, parameterised by depth and providing push, pop, full, empty, head and per-entry valid/rd taps.

Verification
REQ-037 Scenario, ALU only: alu_valid=1, rd=5, data=0xDEADBEEF in cycle 0 -> cycle 1 shows we=1, rd_addr=5, rd_data_in=0xDEADBEEF.
REQ-038 Scenario, contention: ALU (rd=3) and load (rd=4, 0x11) both valid in cycle 0 -> ALU is written in cycle 1, the load is written in cycle 2, and busy_mask[4]=1 during cycle 1 only.
REQ-039 Scenario, FIFO full: with LD_DEPTH=2 and alu_valid held high:
  - two loads fill the FIFO, then ld_ready=0 and alu_ready=0;
  - the head pops and is written the next cycle;
  - alu_ready returns to 1 once count < 2.
REQ-040 Scenario, x0 write: alu_rd=0, data=0xFFFFFFFF -> alu_ready=1 and we stays 0.
REQ-041 Scenario, bypass (WB_BYPASS_EN defined): we=1, rd_addr=7, rd_data_in=0x1234 and rs1_addr=7 -> rs1_fwd_hit=1 and rs1_fwd_data=0x1234; with rs2_addr=0, rs2_fwd_hit=0.
REQ-042 Scenario, reset mid-run: assert rst low asynchronously with two loads buffered -> immediately we=0, busy_mask=0, ld_ready=1, and no stale write appears after release.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package wb_arbiter_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // One register-file write request
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_ld_fifo.sv
// Load-result FIFO: in-order buffer of write requests with per-entry
// valid/rd taps so the top level can build a busy mask.
module wb_ld_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  wb_req_t               push_req_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output wb_req_t               head_o,
  output logic [DEPTH-1:0]      ent_valid_o,
  output logic [REG_ADDR_W-1:0] ent_rd_o [DEPTH]
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_req_t           mem_q   [DEPTH];
  wb_req_t           mem_d   [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign ent_valid_o = valid_q;

  // Per-entry rd taps
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_rd_o[i] = mem_q[i].rd;
    end
  end

  // Next-state: pointers wrap modulo DEPTH; push+pop leaves count unchanged
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (pop_i && !empty_o) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end
    if (push_i && !full_o) begin
      mem_d[wptr_q]   = push_req_i;
      valid_d[wptr_q] = 1'b1;
      wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
    case ({push_i && !full_o, pop_i && !empty_o})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state register; reset discards all buffered entries
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and buffered load results onto a
// single registered register-file write port. ALU wins unless the load
// FIFO is full. Optional bypass outputs enabled by macro WB_BYPASS_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned LD_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       rd_data_in,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_fwd_hit,
  output logic                  rs2_fwd_hit,
  output logic [XLEN-1:0]       rs1_fwd_data,
  output logic [XLEN-1:0]       rs2_fwd_data,
  output logic [XLEN-1:0]       busy_mask
);

  logic                  fifo_full, fifo_empty;
  wb_req_t               fifo_head;
  logic [LD_DEPTH-1:0]   ent_valid;
  logic [REG_ADDR_W-1:0] ent_rd [LD_DEPTH];

  logic    alu_xfer, ld_push, ld_pop, win_valid;
  wb_req_t win;

  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]       rd_data_q, rd_data_d;

  assign alu_ready = !fifo_full;
  assign ld_ready  = !fifo_full;
  assign alu_xfer  = alu_valid && alu_ready;
  assign ld_push   = ld_valid && ld_ready;
  assign ld_pop    = fifo_full || (!alu_xfer && !fifo_empty);

  wb_ld_fifo #(
    .DEPTH (LD_DEPTH)
  ) u_ld_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (ld_push),
    .push_req_i  ('{rd: ld_rd, data: ld_data}),
    .pop_i       (ld_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head),
    .ent_valid_o (ent_valid),
    .ent_rd_o    (ent_rd)
  );

  // Winner select; an rd=0 winner is consumed without a write and the
  // address/data registers keep their last written values
  always_comb begin
    win_valid = alu_xfer || ld_pop;
    win       = alu_xfer ? wb_req_t'{rd: alu_rd, data: alu_data} : fifo_head;
    we_d      = win_valid && (win.rd != REG_ZERO);
    rd_addr_d = we_d ? win.rd   : rd_addr_q;
    rd_data_d = we_d ? win.data : rd_data_q;
  end

  // Registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q      <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      we_q      <= we_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign we         = we_q;
  assign rd_addr    = rd_addr_q;
  assign rd_data_in = rd_data_q;

  // Busy mask: OR-decode of buffered load destinations, x0 excluded
  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < LD_DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] != REG_ZERO)) begin
        busy_mask[ent_rd[i]] = 1'b1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the value currently on the write port to decode
  always_comb begin
    rs1_fwd_hit  = we_q && (rd_addr_q != REG_ZERO) && (rd_addr_q == rs1_addr);
    rs2_fwd_hit  = we_q && (rd_addr_q != REG_ZERO) && (rd_addr_q == rs2_addr);
    rs1_fwd_data = rd_data_q;
    rs2_fwd_data = rd_data_q;
  end
`else
  logic unused_rs;
  assign unused_rs    = ^{rs1_addr, rs2_addr};
  assign rs1_fwd_hit  = 1'b0;
  assign rs2_fwd_hit  = 1'b0;
  assign rs1_fwd_data = '0;
  assign rs2_fwd_data = '0;
`endif

endmodule
